// File: rtl/pe_seq_if.sv
// Signal bundle between the PE sequencer and its environment: job control,
// weight/activation/psum streams and the processing-element control port.
interface pe_seq_if #(
    parameter int dataSize   = 8,
    parameter int macResSize = 20
);
    logic                  job_start_i;
    logic [7:0]            cfg_wcount_i;
    logic [7:0]            cfg_acount_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [dataSize-1:0]   w_data_i;
    logic                  a_valid_i;
    logic                  a_ready_o;
    logic [dataSize-1:0]   a_data_i;
    logic                  psin_valid_i;
    logic                  psin_ready_o;
    logic [macResSize-1:0] psin_data_i;
    logic [dataSize-1:0]   pe_weights_o;
    logic [dataSize-1:0]   pe_acts_o;
    logic                  pe_loadw_o;
    logic                  pe_loada_o;
    logic                  pe_start_o;
    logic                  pe_sums_o;
    logic [7:0]            pe_wcount_o;
    logic [7:0]            pe_acount_o;
    logic [macResSize-1:0] pe_psum_o;
    logic                  pe_done_i;
    logic [macResSize-1:0] pe_psum_i;
    logic                  psout_valid_o;
    logic [macResSize-1:0] psout_data_o;

    modport slave (
        input  job_start_i, cfg_wcount_i, cfg_acount_i,
        input  w_valid_i, w_data_i, a_valid_i, a_data_i,
        input  psin_valid_i, psin_data_i, pe_done_i, pe_psum_i,
        output busy_o, done_o, err_o, w_ready_o, a_ready_o, psin_ready_o,
        output pe_weights_o, pe_acts_o, pe_loadw_o, pe_loada_o, pe_start_o,
        output pe_sums_o, pe_wcount_o, pe_acount_o, pe_psum_o,
        output psout_valid_o, psout_data_o
    );

    modport master (
        output job_start_i, cfg_wcount_i, cfg_acount_i,
        output w_valid_i, w_data_i, a_valid_i, a_data_i,
        output psin_valid_i, psin_data_i, pe_done_i, pe_psum_i,
        input  busy_o, done_o, err_o, w_ready_o, a_ready_o, psin_ready_o,
        input  pe_weights_o, pe_acts_o, pe_loadw_o, pe_loada_o, pe_start_o,
        input  pe_sums_o, pe_wcount_o, pe_acount_o, pe_psum_o,
        input  psout_valid_o, psout_data_o
    );
endinterface

// File: rtl/pe_seq.sv
// Job sequencer for one processing element: loads W weights and A activations,
// kicks the PE, then feeds N = A+1-W incoming partial sums through it.
module pe_seq #(
    parameter int dataSize   = 8,
    parameter int macResSize = 20,
    parameter int spadNReg   = 16
) (
    input  logic      clk,
    input  logic      rst,
    pe_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOADW, S_LOADA, S_START, S_RUN, S_SUMS, S_DRAIN
    } state_t;

    localparam logic [7:0] SPAD_MAX = 8'(spadNReg);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_next;
    logic [7:0]            r_wcount;
    logic [7:0]            r_acount;
    logic [7:0]            r_ncount;
    logic                  r_err;
    logic                  r_psout_valid;
    logic                  w_cfg_bad;
    logic                  w_accept;
    logic                  w_hs_w;
    logic                  w_hs_a;
    logic                  w_hs_p;
    logic [7:0]            w_cnt_inc;
    logic [dataSize-1:0]   w_weights;
    logic [dataSize-1:0]   w_acts;
    logic [macResSize-1:0] w_psum;

    assign w_cfg_bad = (bus.cfg_wcount_i == 8'd0) || (bus.cfg_acount_i == 8'd0) ||
                       (bus.cfg_wcount_i > bus.cfg_acount_i) ||
                       (bus.cfg_wcount_i > SPAD_MAX) || (bus.cfg_acount_i > SPAD_MAX);
    assign w_accept  = (r_state == S_IDLE) && bus.job_start_i && !w_cfg_bad;

    assign w_hs_w    = (r_state == S_LOADW) && bus.w_valid_i;
    assign w_hs_a    = (r_state == S_LOADA) && bus.a_valid_i;
    assign w_hs_p    = (r_state == S_SUMS)  && bus.psin_valid_i;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = 8'd0;
                if (w_accept) w_state_next = S_LOADW;
            end
            S_LOADW: if (w_hs_w) begin
                w_cnt_next = (w_cnt_inc == r_wcount) ? 8'd0 : w_cnt_inc;
                if (w_cnt_inc == r_wcount) w_state_next = S_LOADA;
            end
            S_LOADA: if (w_hs_a) begin
                w_cnt_next = (w_cnt_inc == r_acount) ? 8'd0 : w_cnt_inc;
                if (w_cnt_inc == r_acount) w_state_next = S_START;
            end
            S_START: w_state_next = S_RUN;
            S_RUN:   if (bus.pe_done_i) w_state_next = S_SUMS;
            S_SUMS: if (w_hs_p) begin
                w_cnt_next = (w_cnt_inc == r_ncount) ? 8'd0 : w_cnt_inc;
                if (w_cnt_inc == r_ncount) w_state_next = S_DRAIN;
            end
            S_DRAIN: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_wcount      <= 8'd0;
            r_acount      <= 8'd0;
            r_ncount      <= 8'd0;
            r_err         <= 1'b0;
            r_psout_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_err         <= (r_state == S_IDLE) && bus.job_start_i && w_cfg_bad;
            r_psout_valid <= w_hs_p;
            // N is only formed from a config that passed the check, so A+1-W >= 1.
            if (w_accept) begin
                r_wcount <= bus.cfg_wcount_i;
                r_acount <= bus.cfg_acount_i;
                r_ncount <= bus.cfg_acount_i + 8'd1 - bus.cfg_wcount_i;
            end
        end
    end

    assign w_weights = (r_state == S_LOADW) ? bus.w_data_i    : '0;
    assign w_acts    = (r_state == S_LOADA) ? bus.a_data_i    : '0;
    assign w_psum    = (r_state == S_SUMS)  ? bus.psin_data_i : '0;

    assign bus.busy_o        = (r_state != S_IDLE);
    assign bus.done_o        = (r_state == S_DRAIN);
    assign bus.err_o         = r_err;
    assign bus.w_ready_o     = (r_state == S_LOADW);
    assign bus.a_ready_o     = (r_state == S_LOADA);
    assign bus.psin_ready_o  = w_hs_p;
    assign bus.pe_weights_o  = w_weights;
    assign bus.pe_acts_o     = w_acts;
    assign bus.pe_loadw_o    = w_hs_w;
    assign bus.pe_loada_o    = w_hs_a;
    assign bus.pe_start_o    = (r_state == S_START);
    assign bus.pe_sums_o     = w_hs_p;
    assign bus.pe_wcount_o   = r_wcount;
    assign bus.pe_acount_o   = r_acount;
    assign bus.pe_psum_o     = w_psum;
    assign bus.psout_valid_o = r_psout_valid;
    assign bus.psout_data_o  = bus.pe_psum_i;
endmodule

// File: doc/pe_seq.md
PE_SEQ -- requirements
Module: pe_seq

Interface
REQ-001 Parameter dataSize, default 8, width of weight/activation words.
REQ-002 Parameter macResSize, default 20, width of partial sums (2*dataSize+4).
REQ-003 Parameter spadNReg, default 16, max weights and max activations per job.
REQ-004 The block SHALL use one clock `clk`; reset `rst` is synchronous and active-high.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- job_start_i  in  1  pulse; latches counts
- cfg_wcount_i  in  8  weights per job
- cfg_acount_i  in  8  activations per job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- err_o  out  1  one-cycle bad-config pulse
- w_valid_i / w_ready_o  in / out  1  weight stream handshake
- w_data_i  in  dataSize  weight word
- a_valid_i / a_ready_o  in / out  1  activation stream handshake
- a_data_i  in  dataSize  activation word
- psin_valid_i / psin_ready_o  in / out  1  incoming psum handshake
- psin_data_i  in  macResSize  incoming psum
- pe_weights_o, pe_acts_o  out  dataSize  to PE
- pe_loadw_o, pe_loada_o, pe_start_o, pe_sums_o  out  1  PE controls
- pe_wcount_o, pe_acount_o  out  8  latched counts to PE
- pe_psum_o  out  macResSize  psum into PE
- pe_done_i  in  1  PE flag_done
- pe_psum_i  in  macResSize  PE psum output
- psout_valid_o  out  1  output psum valid; no backpressure
- psout_data_o  out  macResSize  output psum

Function
REQ-006 FSM states: IDLE, LOADW, LOADA, START, RUN, SUMS, DRAIN.
REQ-007 IDLE: on job_start_i, latch W=cfg_wcount_i, A=cfg_acount_i, N=A+1-W; go to LOADW.
REQ-008 Bad config (W==0, A==0, W>A, W>spadNReg or A>spadNReg) SHALL pulse err_o the next cycle and stay in IDLE.
REQ-009 job_start_i outside IDLE SHALL be ignored.
REQ-010 LOADW: w_ready_o=1; pe_loadw_o=w_valid_i; pe_weights_o=w_data_i.
REQ-011 LOADW: count handshakes; after the W-th, go to LOADA; gaps (w_valid_i=0) allowed.
REQ-012 LOADA: same rules with a_* and pe_loada_o; after the A-th handshake, go to START.
REQ-013 START: pe_start_o=1 for exactly one cycle; then RUN.
REQ-014 RUN: wait for pe_done_i=1, then go to SUMS; no timeout.
REQ-015 SUMS: pe_sums_o=psin_valid_i; psin_ready_o=psin_valid_i; pe_psum_o=psin_data_i.
REQ-016 SUMS: count handshakes; after the N-th, go to DRAIN.
REQ-017 psout_valid_o SHALL be pe_sums_o registered by one cycle.
REQ-018 psout_data_o SHALL be pe_psum_i passed through combinationally.
REQ-019 DRAIN: lasts one cycle (emits the last psout); done_o=1 that cycle; next state IDLE.
REQ-020 busy_o=1 in every state except IDLE.
REQ-021 pe_wcount_o/pe_acount_o SHALL hold the latched W/A from job accept until the next accept.
REQ-022 All ready and PE-control outputs SHALL be 0 outside their owning state.
REQ-023 Count comparisons SHALL use 8-bit unsigned arithmetic; N is computed only after the config check passes, so it never underflows.

Reset
REQ-024 rst=1 at any edge, including mid-job, SHALL force IDLE and clear all counters.
REQ-025 Reset SHALL clear all outputs to 0, including latched counts, psout_valid_o, done_o and err_o.
REQ-026 The first job_start_i is accepted on the first cycle with rst=0.

Verification
REQ-027 W=3, A=16, continuous streams, PE model with done after 20 cycles, psin=1 for all sums.
-> 3 pe_loadw_o cycles, 16 pe_loada_o, 1 pe_start_o; exactly 14 psout_valid_o cycles; done_o once; busy_o low after.
REQ-028 W=3, A=16 with w_valid_i/a_valid_i toggling every other cycle.
-> still exactly 3/16 loads; load data order preserved.
REQ-029 psin_valid_i stalled 5 cycles mid-SUMS.
-> pe_sums_o=0 during the stall; psout_valid_o gaps one cycle later; total still 14.
REQ-030 Bad configs (W=0; W=5,A=4; A=17).
-> err_o pulse each time; busy_o stays 0; no PE controls assert.
REQ-031 rst asserted during RUN, then a new job W=2, A=4.
-> IDLE next cycle, all outputs 0; new job completes with 3 psout_valid_o.
REQ-032 job_start_i pulsed during LOADA.
-> ignored; counts and the job result are unchanged.
